// File: rtl/param_data_stack.sv
`default_nettype none
// ============================================================================
// Module      : param_data_stack
// Description : Parametrised data/return stack for a J1-style core. The top
//               of stack (T) lives in a register; next-on-stack (N) is a
//               combinational read of the memory array at sp-1. Supports
//               pointer deltas of +1, 0, -1 and -2, occupancy tracking,
//               sticky overflow/underflow flags and a choice between
//               rejecting or wrapping on overflow/underflow.
// Ports       : clk, rst_n       - clock, synchronous active-low reset
//               op_valid         - perform the operation this cycle
//               delta[1:0]       - 00:0  01:+1 push  11:-1 pop  10:-2 pop two
//               t_wen, t_in      - load t_in into T on a valid op
//               clr_err          - clear sticky ovf/unf
//               T, N             - top / next on stack
//               count            - memory entries in use (0..DEPTH)
//               full, empty      - decoded from count
//               ovf, unf         - sticky error flags
//               err_pulse        - one cycle per erroneous op
// Revision    : 1.0 - initial release
// ============================================================================
module param_data_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int WRAP  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [1:0]       delta,
    input  logic             t_wen,
    input  logic [WIDTH-1:0] t_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] T,
    output logic [WIDTH-1:0] N,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf,
    output logic             err_pulse
);

    localparam logic [1:0]     c_D_NOP    = 2'b00;
    localparam logic [1:0]     c_D_PUSH   = 2'b01;
    localparam logic [1:0]     c_D_POP1   = 2'b11;
    localparam logic [1:0]     c_D_POP2   = 2'b10;
    localparam logic [PTR_W:0] c_CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] c_CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] c_CNT_TWO  = (PTR_W+1)'(2);
    localparam logic [PTR_W-1:0] c_SP_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0] c_SP_TWO = PTR_W'(2);
    localparam bit             c_REJECT   = (WRAP == 0);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_t;
    logic [PTR_W-1:0] r_sp;
    logic [PTR_W:0]   r_cnt;
    logic             r_ovf;
    logic             r_unf;
    logic             r_err_pulse;

    logic [PTR_W-1:0] w_sp_m1;
    logic [PTR_W-1:0] w_sp_m2;
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;
    logic             w_ovf_ev;
    logic             w_unf_ev;
    logic             w_reject;
    logic             w_mem_we;
    logic [PTR_W-1:0] w_sp_nxt;
    logic [PTR_W:0]   w_cnt_nxt;
    logic [WIDTH-1:0] w_t_nxt;

    // Two combinational read ports: sp-1 feeds N and pop, sp-2 feeds pop-two.
    assign w_sp_m1 = r_sp - c_SP_ONE;
    assign w_sp_m2 = r_sp - c_SP_TWO;
    assign w_rd1   = r_mem[w_sp_m1];
    assign w_rd2   = r_mem[w_sp_m2];

    // Error events are judged on occupancy, not on the pointer.
    assign w_ovf_ev = op_valid && (delta == c_D_PUSH) && (r_cnt == c_CNT_FULL);
    assign w_unf_ev = op_valid && (((delta == c_D_POP1) && (r_cnt == '0)) ||
                                   ((delta == c_D_POP2) && (r_cnt < c_CNT_TWO)));
    assign w_reject = c_REJECT && (w_ovf_ev || w_unf_ev);

    always_comb begin
        w_sp_nxt  = r_sp;
        w_cnt_nxt = r_cnt;
        w_t_nxt   = r_t;
        w_mem_we  = 1'b0;
        if (op_valid && !w_reject) begin
            case (delta)
                c_D_NOP: begin
                    if (t_wen) begin
                        w_t_nxt = t_in;
                    end
                end
                c_D_PUSH: begin
                    // In wrap mode a full push overwrites the oldest slot,
                    // so occupancy stays pinned at DEPTH.
                    w_mem_we  = 1'b1;
                    w_sp_nxt  = r_sp + c_SP_ONE;
                    w_cnt_nxt = w_ovf_ev ? r_cnt : (r_cnt + c_CNT_ONE);
                    w_t_nxt   = t_wen ? t_in : r_t;
                end
                c_D_POP1: begin
                    w_sp_nxt  = w_sp_m1;
                    w_cnt_nxt = w_unf_ev ? '0 : (r_cnt - c_CNT_ONE);
                    w_t_nxt   = t_wen ? t_in : w_rd1;
                end
                c_D_POP2: begin
                    w_sp_nxt  = w_sp_m2;
                    w_cnt_nxt = w_unf_ev ? '0 : (r_cnt - c_CNT_TWO);
                    w_t_nxt   = t_wen ? t_in : w_rd2;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_t         <= '0;
            r_sp        <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_t         <= w_t_nxt;
            r_sp        <= w_sp_nxt;
            r_cnt       <= w_cnt_nxt;
            // A fresh error outranks a simultaneous clear.
            r_ovf       <= w_ovf_ev | (r_ovf & ~clr_err);
            r_unf       <= w_unf_ev | (r_unf & ~clr_err);
            r_err_pulse <= w_ovf_ev | w_unf_ev;
        end
    end

    // Storage is never cleared; the write is still blocked under reset so a
    // push that coincides with reset leaves no trace.
    always_ff @(posedge clk) begin
        if (rst_n && w_mem_we) begin
            r_mem[r_sp] <= r_t;
        end
    end

    assign T         = r_t;
    assign N         = (c_REJECT && (r_cnt == '0)) ? '0 : w_rd1;
    assign count     = r_cnt;
    assign full      = (r_cnt == c_CNT_FULL);
    assign empty     = (r_cnt == '0);
    assign ovf       = r_ovf;
    assign unf       = r_unf;
    assign err_pulse = r_err_pulse;

endmodule
`default_nettype wire
